// File: rtl/ripple_count_monitor_pkg.sv
// Shared types, default parameters and the modular-delta classifier for the
// ripple counter monitor.
package ripple_mon_pkg;

    localparam int DEF_WIDTH         = 4;
    localparam int DEF_STABLE_CYCLES = 3;
    localparam int DEF_EPOCH_W       = 8;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        D_NONE = 2'd0,
        D_UP   = 2'd1,
        D_DOWN = 2'd2,
        D_SKIP = 2'd3
    } delta_kind_t;

    // d is (new - old) already reduced modulo 2^w by the caller's width.
    function automatic delta_kind_t classify_delta(input logic [31:0] d, input int w);
        logic [31:0] mask;
        logic [31:0] dm;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        dm   = d & mask;
        if (dm == 32'd0)
            return D_NONE;
        else if (dm == 32'd1)
            return D_UP;
        else if (dm == mask)
            return D_DOWN;
        else
            return D_SKIP;
    endfunction

endpackage

// File: rtl/ripple_count_monitor_if.sv
// Bundle between the raw ripple counter (master) and the monitor (slave),
// including the monitor FSM state for observation.
interface ripple_mon_if
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int EPOCH_W = DEF_EPOCH_W
);
    // count_in/up_or_down are free-running level signals with no handshake;
    // every monitor output pulse lasts exactly one clk cycle, sticky flags hold.
    logic [WIDTH-1:0]   count_in;
    logic               up_or_down;
    logic [WIDTH-1:0]   count_q;
    logic               count_valid;
    logic               step_up;
    logic               step_down;
    logic               wrap;
    logic [EPOCH_W-1:0] epoch;
    logic               skip_err;
    logic               dir_err;
    state_t             state;

    modport master (
        output count_in, up_or_down,
        input  count_q, count_valid, step_up, step_down, wrap, epoch,
               skip_err, dir_err, state
    );

    modport slave (
        input  count_in, up_or_down,
        output count_q, count_valid, step_up, step_down, wrap, epoch,
               skip_err, dir_err, state
    );
endinterface

// File: rtl/ripple_count_monitor_sync_2ff.sv
// Two-flop synchronizer, one pair per bit, cleared synchronously.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;
endmodule

// File: rtl/ripple_count_monitor.sv
// Synchronizes, debounces and classifies the ripple counter output, keeping
// an epoch (wrap) count and sticky skip/direction error flags.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int EPOCH_W       = DEF_EPOCH_W
) (
    input  logic        clk,
    input  logic        clear,
    ripple_mon_if.slave bus
);
    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;

    logic [WIDTH-1:0]   w_cnt_s;
    logic               w_dir_s;
    logic               w_stable;
    logic [WIDTH-1:0]   w_delta;
    delta_kind_t        w_kind;

    logic [WIDTH-1:0]   r_cand;
    logic [STAB_W-1:0]  r_stab;
    state_t             r_state;
    logic [WIDTH-1:0]   r_count_q;
    logic               r_count_valid;
    logic               r_step_up;
    logic               r_step_down;
    logic               r_wrap;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_skip_err;
    logic               r_dir_err;

    sync_2ff #(.W(WIDTH)) u_sync_cnt (
        .clk   (clk),
        .clear (clear),
        .d     (bus.count_in),
        .q     (w_cnt_s)
    );

    sync_2ff #(.W(1)) u_sync_dir (
        .clk   (clk),
        .clear (clear),
        .d     (bus.up_or_down),
        .q     (w_dir_s)
    );

    // Any change restarts the count, so a value must be seen STABLE_CYCLES times in a row.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_cand <= '0;
            r_stab <= '0;
        end else if (w_cnt_s != r_cand) begin
            r_cand <= w_cnt_s;
            r_stab <= '0;
        end else if (r_stab != STAB_MAX) begin
            r_stab <= r_stab + STAB_W'(1);
        end
    end

    assign w_stable = (w_cnt_s == r_cand) && (r_stab == STAB_MAX);
    assign w_delta  = r_cand - r_count_q;
    assign w_kind   = classify_delta(32'(w_delta), WIDTH);

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state       <= INIT;
            r_count_q     <= '0;
            r_count_valid <= 1'b0;
            r_step_up     <= 1'b0;
            r_step_down   <= 1'b0;
            r_wrap        <= 1'b0;
            r_epoch       <= '0;
            r_skip_err    <= 1'b0;
            r_dir_err     <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            r_step_up     <= 1'b0;
            r_step_down   <= 1'b0;
            r_wrap        <= 1'b0;
            case (r_state)
                INIT: begin
                    if (w_stable) begin
                        r_count_q     <= r_cand;
                        r_count_valid <= 1'b1;
                        r_state       <= TRACK;
                    end
                end
                TRACK: begin
                    if (w_stable && (r_cand != r_count_q)) begin
                        r_count_q     <= r_cand;
                        r_count_valid <= 1'b1;
                        case (w_kind)
                            D_UP: begin
                                r_step_up <= 1'b1;
                                if (!w_dir_s)
                                    r_dir_err <= 1'b1;
                                if (r_count_q == CNT_MAX) begin
                                    r_wrap  <= 1'b1;
                                    r_epoch <= r_epoch + EPOCH_W'(1);
                                end
                            end
                            D_DOWN: begin
                                r_step_down <= 1'b1;
                                if (w_dir_s)
                                    r_dir_err <= 1'b1;
                                if (r_count_q == '0) begin
                                    r_wrap  <= 1'b1;
                                    r_epoch <= r_epoch - EPOCH_W'(1);
                                end
                            end
                            D_SKIP:  r_skip_err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.count_q     = r_count_q;
    assign bus.count_valid = r_count_valid;
    assign bus.step_up     = r_step_up;
    assign bus.step_down   = r_step_down;
    assign bus.wrap        = r_wrap;
    assign bus.epoch       = r_epoch;
    assign bus.skip_err    = r_skip_err;
    assign bus.dir_err     = r_dir_err;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: reset, latency, stepping, wrap,
// glitch rejection, skip/direction errors and clear mid-filter.
module tb_ripple_count_monitor;
    import ripple_mon_pkg::*;

    logic clk;
    logic clear;

    int n_cmp;
    int n_err;
    int n_valid, n_up, n_down, n_wrap, n_bad;
    int b_valid, b_up, b_down, b_wrap;

    ripple_mon_if #(.WIDTH(4), .EPOCH_W(8)) bus ();

    ripple_count_monitor #(.WIDTH(4), .STABLE_CYCLES(3), .EPOCH_W(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies plus structural checks on pulse combinations.
    always @(posedge clk) begin
        #1;
        if (bus.count_valid) n_valid++;
        if (bus.step_up)     n_up++;
        if (bus.step_down)   n_down++;
        if (bus.wrap)        n_wrap++;
        if (bus.step_up && bus.step_down) n_bad++;
        if (bus.wrap && !(bus.step_up ^ bus.step_down)) n_bad++;
        if ((bus.step_up || bus.step_down) && !bus.count_valid) n_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_up    = n_up;
        b_down  = n_down;
        b_wrap  = n_wrap;
    endtask

    task automatic present(input logic [3:0] v, input int cycles);
        @(negedge clk);
        bus.count_in = v;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        n_valid = 0; n_up = 0; n_down = 0; n_wrap = 0; n_bad = 0;
        bus.count_in   = 4'h0;
        bus.up_or_down = 1'b1;
        clear          = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_count_q",  32'(bus.count_q), 32'h0);
        check("rst_valid",    32'(bus.count_valid), 32'h0);
        check("rst_epoch",    32'(bus.epoch), 32'h0);
        check("rst_skip",     32'(bus.skip_err), 32'h0);
        check("rst_dir",      32'(bus.dir_err), 32'h0);
        check("rst_state",    32'(bus.state), 32'(INIT));

        // 1: first acceptance after clear, exact latency
        snap();
        clear = 1'b0;
        bus.count_in = 4'h5;
        repeat (5) @(negedge clk);
        check("t1_early_valid", 32'(bus.count_valid), 32'h0);
        @(negedge clk);
        check("t1_valid",     32'(bus.count_valid), 32'h1);
        check("t1_count_q",   32'(bus.count_q), 32'h5);
        check("t1_step_up",   32'(bus.step_up), 32'h0);
        check("t1_wrap",      32'(bus.wrap), 32'h0);
        check("t1_state",     32'(bus.state), 32'(TRACK));
        @(negedge clk);
        check("t1_pulse_len", 32'(bus.count_valid), 32'h0);
        repeat (8) @(negedge clk);
        check("t1_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("t1_epoch",     32'(bus.epoch), 32'h0);
        check("t1_skip",      32'(bus.skip_err), 32'h0);

        // 2: two up steps
        snap();
        present(4'h6, 8);
        present(4'h7, 8);
        check("t2_valid_cnt", 32'(n_valid - b_valid), 32'd2);
        check("t2_up_cnt",    32'(n_up - b_up), 32'd2);
        check("t2_count_q",   32'(bus.count_q), 32'h7);
        check("t2_dir_err",   32'(bus.dir_err), 32'h0);

        // 3: up-wrap then down-wrap
        for (int v = 8; v <= 15; v++) present(4'(v), 8);
        check("t3_at_max",    32'(bus.count_q), 32'hF);
        snap();
        present(4'h0, 8);
        check("t3_upw_up",    32'(n_up - b_up), 32'd1);
        check("t3_upw_wrap",  32'(n_wrap - b_wrap), 32'd1);
        check("t3_upw_epoch", 32'(bus.epoch), 32'h1);
        bus.up_or_down = 1'b0;
        snap();
        present(4'hF, 8);
        check("t3_dnw_down",  32'(n_down - b_down), 32'd1);
        check("t3_dnw_wrap",  32'(n_wrap - b_wrap), 32'd1);
        check("t3_dnw_epoch", 32'(bus.epoch), 32'h0);
        for (int v = 14; v >= 5; v--) present(4'(v), 8);
        check("t3_back_to_5", 32'(bus.count_q), 32'h5);
        check("t3_dir_err",   32'(bus.dir_err), 32'h0);
        check("t3_skip",      32'(bus.skip_err), 32'h0);

        // 4: short glitch is rejected
        snap();
        present(4'h7, 2);
        present(4'h5, 10);
        check("t4_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        check("t4_count_q",   32'(bus.count_q), 32'h5);

        // 5: skip 5 -> 9, then a legal step keeps the sticky flag
        snap();
        present(4'h9, 8);
        check("t5_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("t5_skip",      32'(bus.skip_err), 32'h1);
        check("t5_steps",     32'((n_up - b_up) + (n_down - b_down)), 32'd0);
        check("t5_wrap",      32'(n_wrap - b_wrap), 32'd0);
        check("t5_epoch",     32'(bus.epoch), 32'h0);
        check("t5_count_q",   32'(bus.count_q), 32'h9);
        bus.up_or_down = 1'b1;
        snap();
        present(4'hA, 8);
        check("t5_up_after",  32'(n_up - b_up), 32'd1);
        check("t5_skip_hold", 32'(bus.skip_err), 32'h1);
        check("t5_dir_err",   32'(bus.dir_err), 32'h0);

        // 6: wrong direction, then clear mid-filter
        bus.up_or_down = 1'b0;
        present(4'h3, 8);
        snap();
        present(4'h4, 8);
        check("t6_up",        32'(n_up - b_up), 32'd1);
        check("t6_dir_err",   32'(bus.dir_err), 32'h1);
        present(4'h6, 3);
        bus.count_in = 4'h4;
        clear = 1'b1;
        @(negedge clk);
        check("t6_clr_count_q", 32'(bus.count_q), 32'h0);
        check("t6_clr_dir",     32'(bus.dir_err), 32'h0);
        check("t6_clr_skip",    32'(bus.skip_err), 32'h0);
        check("t6_clr_epoch",   32'(bus.epoch), 32'h0);
        check("t6_clr_state",   32'(bus.state), 32'(INIT));
        snap();
        clear = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_early_valid", 32'(bus.count_valid), 32'h0);
        @(negedge clk);
        check("t6_valid",     32'(bus.count_valid), 32'h1);
        check("t6_count_q",   32'(bus.count_q), 32'h4);
        check("t6_no_step",   32'((n_up - b_up) + (n_down - b_down)), 32'd0);
        repeat (4) @(negedge clk);
        check("t6_valid_cnt", 32'(n_valid - b_valid), 32'd1);

        check("pulse_rules",  32'(n_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
